rhd_headstage_emulator: RTL and testbench

Parametrised, synthesizable emulator of an RHD2000-family headstage SPI slave for bench and loopback testing of the host SPI master. It oversamples CS/SCLK/MOSI on the system clock, decodes the 16-bit CONVERT, READ, WRITE and CALIBRATE commands, and keeps per-channel sample counters plus a register file. Each response is returned on MISO with the chip's two-frame pipeline latency. It sits where a physical headstage would, on the SPI pins of the acquisition front end.

---
 rtl/rhd_headstage_emulator.sv | 167 ++++++++++++++++
 tb/tb_rhd_headstage_emulator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rhd_headstage_emulator.sv
// rhd_headstage_emulator
//   Emulates an RHD2000-family headstage SPI slave for loopback testing of a
//   host SPI master. CS/SCLK/MOSI are oversampled on clk, 16-bit commands are
//   decoded (CONVERT, WRITE, READ, other), and each result comes back on MISO
//   two frames later, as on the real chip.
// Ports
//   clk         system clock, at least 8x SCLK
//   rst_n       asynchronous active-low reset
//   CS          SPI chip select, active low, asynchronous to clk
//   SCLK        SPI clock, idle low, asynchronous to clk
//   MOSI        command bit, MSB first, sampled on SCLK rise
//   MISO        response bit, MSB first, updated on SCLK fall
//   frame_done  one-clk pulse after a complete 16-bit frame is executed
//   last_cmd    last executed command word
module rhd_headstage_emulator #(
   parameter int          NUM_CHANNELS  = 32,
   parameter logic [15:0] STARTING_SEED = 16'd0,
   parameter logic [15:0] SEED_STEP     = 16'd1,
   parameter logic [7:0]  CHIP_ID       = 8'd1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        CS,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        frame_done,
   output logic [15:0] last_cmd
);

   localparam int NUM_REGS = 22;

   typedef enum logic [1:0] {IDLE, SHIFT, EXEC} state_t;

   state_t      state;
   logic [1:0]  cs_sync, sclk_sync, mosi_sync;
   logic        cs_prev, sclk_prev;
   logic        cs_fall, cs_rise, sclk_rise, sclk_fall;
   logic [15:0] cmd;
   logic [15:0] resp;
   logic [4:0]  bit_cnt;
   logic [15:0] slot1, slot2;
   logic [15:0] counter [NUM_CHANNELS];
   logic [7:0]  reg_file [NUM_REGS];
   logic [5:0]  field;
   logic [15:0] result;
   logic [7:0]  read_val;

   // The CS synchronizer resets low so that a CS already low at reset release
   // is not mistaken for a new falling edge; the block waits for a fresh fall.
   // NOTE: state elements use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, matching the hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync   <= '0;
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_prev   <= 1'b0;
         sclk_prev <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[0], CS};
         sclk_sync <= {sclk_sync[0], SCLK};
         mosi_sync <= {mosi_sync[0], MOSI};
         cs_prev   <= cs_sync[1];
         sclk_prev <= sclk_sync[1];
      end
   end

   assign cs_fall   =  cs_prev   & ~cs_sync[1];
   assign cs_rise   = ~cs_prev   &  cs_sync[1];
   assign sclk_rise = ~sclk_prev &  sclk_sync[1];
   assign sclk_fall =  sclk_prev & ~sclk_sync[1];

   assign field = cmd[13:8];

   // Result of the command currently held in cmd; consumed only in EXEC.
   // NOTE: every variable gets a default at the top so no path can leave it
   // unassigned and infer a latch.
   always_comb begin
      result   = '0;
      read_val = '0;
      case (cmd[15:14])
         2'b00: begin
            for (int c = 0; c < NUM_CHANNELS; c++)
               if (field == 6'(c)) result = counter[c];
         end
         2'b10: result = {8'hFF, cmd[7:0]};
         2'b11: begin
            for (int r = 0; r < NUM_REGS; r++)
               if (field == 6'(r)) read_val = reg_file[r];
            case (field)
               6'd40:   read_val = 8'h49;
               6'd41:   read_val = 8'h4E;
               6'd42:   read_val = 8'h54;
               6'd43:   read_val = 8'h41;
               6'd44:   read_val = 8'h4E;
               6'd63:   read_val = CHIP_ID;
               default: ;
            endcase
            result = {8'h00, read_val};
         end
         default: result = '0;
      endcase
   end

   // NOTE: the channel counters and register file are reset explicitly because
   // their reset contents are architecturally visible through CONVERT and READ.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cmd        <= '0;
         resp       <= '0;
         bit_cnt    <= '0;
         MISO       <= 1'b0;
         frame_done <= 1'b0;
         last_cmd   <= '0;
         slot1      <= '0;
         slot2      <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) counter[c] <= STARTING_SEED + 16'(c);
         for (int r = 0; r < NUM_REGS; r++) reg_file[r] <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state   <= SHIFT;
                  resp    <= slot2;
                  MISO    <= slot2[15];
                  bit_cnt <= '0;
                  cmd     <= '0;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  MISO  <= 1'b0;
                  // Anything but exactly 16 SCLKs aborts the frame silently.
                  state <= (bit_cnt == 5'd16) ? EXEC : IDLE;
               end else begin
                  if (sclk_rise) begin
                     cmd <= {cmd[14:0], mosi_sync[1]};
                     if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                  end
                  if (sclk_fall) begin
                     resp <= {resp[14:0], 1'b0};
                     MISO <= resp[14];
                  end
               end
            end
            EXEC: begin
               slot2      <= slot1;
               slot1      <= result;
               frame_done <= 1'b1;
               last_cmd   <= cmd;
               state      <= IDLE;
               for (int c = 0; c < NUM_CHANNELS; c++)
                  if (cmd[15:14] == 2'b00 && field == 6'(c))
                     counter[c] <= counter[c] + SEED_STEP;
               for (int r = 0; r < NUM_REGS; r++)
                  if (cmd[15:14] == 2'b10 && field == 6'(r))
                     reg_file[r] <= cmd[7:0];
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rhd_headstage_emulator.sv
// Bench for rhd_headstage_emulator. Three instances share the SPI pins and
// differ only in STARTING_SEED (0, 100, 0xFFFF). A behavioural model of the
// chip predicts each frame's MISO word; predictions are queued when a frame
// starts and compared when the frame's bits have been captured.
module tb_rhd_headstage_emulator;

   localparam int ND = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs, sclk, mosi;
   logic [ND-1:0] miso;
   logic [ND-1:0] frame_done;
   logic [15:0] last_cmd_w [ND];

   always #5 clk = ~clk;

   function automatic logic [15:0] seed_of(input int d);
      case (d)
         0:       return 16'd0;
         1:       return 16'd100;
         default: return 16'hFFFF;
      endcase
   endfunction

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam logic [15:0] SEED = (g == 0) ? 16'd0 : (g == 1) ? 16'd100 : 16'hFFFF;
      rhd_headstage_emulator #(
         .NUM_CHANNELS (32),
         .STARTING_SEED(SEED),
         .SEED_STEP    (16'd1),
         .CHIP_ID      (8'h01)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .CS        (cs),
         .SCLK      (sclk),
         .MOSI      (mosi),
         .MISO      (miso[g]),
         .frame_done(frame_done[g]),
         .last_cmd  (last_cmd_w[g])
      );
   end

   int fd_cnt [ND] = '{default: 0};
   always @(posedge clk)
      for (int d = 0; d < ND; d++)
         if (frame_done[d] === 1'b1) fd_cnt[d] <= fd_cnt[d] + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
      end
   endtask

   // ---------------- model ----------------
   logic [15:0] m_cnt [ND][64];
   logic [7:0]  m_reg [ND][64];
   logic [15:0] m_s1 [ND], m_s2 [ND];
   logic [15:0] m_last;

   function automatic logic [7:0] id_rom(input logic [5:0] a);
      case (a)
         6'd40:   return "I";
         6'd41:   return "N";
         6'd42:   return "T";
         6'd43:   return "A";
         6'd44:   return "N";
         6'd63:   return 8'h01;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         for (int c = 0; c < 64; c++) begin
            m_cnt[d][c] = seed_of(d) + 16'(c);
            m_reg[d][c] = 8'h00;
         end
         m_s1[d] = '0;
         m_s2[d] = '0;
      end
      m_last = '0;
   endtask

   task automatic model_exec(input logic [15:0] c);
      logic [15:0] r;
      logic [5:0]  f;
      f = c[13:8];
      for (int d = 0; d < ND; d++) begin
         r = '0;
         if (c[15:14] == 2'b00) begin
            if (f < 6'd32) begin
               r = m_cnt[d][f];
               m_cnt[d][f] = m_cnt[d][f] + 16'd1;
            end
         end else if (c[15:14] == 2'b10) begin
            if (f <= 6'd21) m_reg[d][f] = c[7:0];
            r = {8'hFF, c[7:0]};
         end else if (c[15:14] == 2'b11) begin
            r = (f <= 6'd21) ? {8'h00, m_reg[d][f]} : {8'h00, id_rom(f)};
         end
         m_s2[d] = m_s1[d];
         m_s1[d] = r;
      end
      m_last = c;
   endtask

   // ---------------- scoreboard + host driver ----------------
   typedef struct {
      int          dut;
      logic [15:0] exp;
   } sb_t;
   sb_t sb_q [$];
   logic [15:0] resp_last [ND];

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_frame(input logic [15:0] c, input int nbits);
      logic [15:0] cap [ND];
      logic [15:0] mask;
      int          fd0 [ND];
      sb_t         e;
      mask = 16'hFFFF << (16 - nbits);
      for (int d = 0; d < ND; d++) begin
         sb_q.push_back('{dut: d, exp: m_s2[d] & mask});
         fd0[d] = fd_cnt[d];
         cap[d] = '0;
      end
      cs = 1'b0;
      wait_clk(8);
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < 16) ? c[15-i] : 1'b0;
         wait_clk(8);
         for (int d = 0; d < ND; d++) cap[d] = {cap[d][14:0], miso[d]};
         sclk = 1'b1;
         wait_clk(8);
         sclk = 1'b0;
      end
      wait_clk(8);
      cs = 1'b1;
      wait_clk(12);
      if (nbits == 16) model_exec(c);
      for (int d = 0; d < ND; d++) begin
         if (nbits < 16) cap[d] = cap[d] << (16 - nbits);
         check($sformatf("miso_cs_high d%0d", d), 16'(miso[d]), 16'h0000);
         check($sformatf("frame_done_count d%0d", d), 16'(fd_cnt[d] - fd0[d]),
               (nbits == 16) ? 16'd1 : 16'd0);
         check($sformatf("last_cmd d%0d", d), last_cmd_w[d], m_last);
      end
      for (int d = 0; d < ND; d++) begin
         e = sb_q.pop_front();
         check($sformatf("resp cmd=%h d%0d", c, e.dut), cap[e.dut], e.exp);
         resp_last[e.dut] = cap[e.dut];
      end
   endtask

   initial begin
      rst_n = 1'b0;
      cs    = 1'b1;
      sclk  = 1'b0;
      mosi  = 1'b0;
      model_reset();
      wait_clk(5);
      for (int d = 0; d < ND; d++) begin
         check($sformatf("reset miso d%0d", d), 16'(miso[d]), 16'h0000);
         check($sformatf("reset frame_done d%0d", d), 16'(frame_done[d]), 16'h0000);
         check($sformatf("reset last_cmd d%0d", d), last_cmd_w[d], 16'h0000);
      end
      rst_n = 1'b1;
      wait_clk(10);

      // CONVERT(0) x4: 0,0,0,1 with seed 0; seed 0xFFFF wraps to 0x0000
      for (int k = 0; k < 4; k++) do_frame(16'h0000, 16);
      check("conv0 f4 seed0", resp_last[0], 16'h0001);
      check("conv0 f4 seedFFFF wrap", resp_last[2], 16'h0000);

      // identification registers, then two dummy CONVERT(63) frames
      begin
         logic [15:0] rd_cmds [8];
         logic [15:0] rd_exp  [6];
         rd_cmds = '{16'hE800, 16'hE900, 16'hEA00, 16'hEB00, 16'hEC00, 16'hFF00,
                     16'h3F00, 16'h3F00};
         rd_exp  = '{16'h0049, 16'h004E, 16'h0054, 16'h0041, 16'h004E, 16'h0001};
         for (int k = 0; k < 8; k++) begin
            do_frame(rd_cmds[k], 16);
            if (k >= 2) check($sformatf("id frame %0d", k + 1), resp_last[0], rd_exp[k-2]);
         end
      end

      // WRITE(5,A7), READ(5); WRITE(30,12), READ(30)
      do_frame(16'h85A7, 16);
      do_frame(16'hC500, 16);
      do_frame(16'h3F00, 16);
      check("write5 echo", resp_last[0], 16'hFFA7);
      do_frame(16'h3F00, 16);
      check("read5", resp_last[0], 16'h00A7);
      do_frame(16'h9E12, 16);
      do_frame(16'hDE00, 16);
      do_frame(16'h3F00, 16);
      check("write30 echo", resp_last[0], 16'hFF12);
      do_frame(16'h3F00, 16);
      check("read30 ignored", resp_last[0], 16'h0000);
      check("conv63 out of range", resp_last[1], 16'h0000);

      // aborted 12-SCLK frame between two CONVERT(3)
      do_frame(16'h0300, 16);
      do_frame(16'h0300, 12);
      do_frame(16'h0300, 16);
      do_frame(16'h3F00, 16);
      check("conv3 first seed100", resp_last[1], 16'd103);
      do_frame(16'h3F00, 16);
      check("conv3 second seed100", resp_last[1], 16'd104);

      // reset after 8 SCLKs of WRITE(2,0x55)
      cs = 1'b0;
      wait_clk(8);
      for (int i = 0; i < 8; i++) begin
         mosi = 16'h8255 >> (15 - i);
         wait_clk(8);
         sclk = 1'b1;
         wait_clk(8);
         sclk = 1'b0;
      end
      rst_n = 1'b0;
      wait_clk(2);
      for (int d = 0; d < ND; d++)
         check($sformatf("midframe reset miso d%0d", d), 16'(miso[d]), 16'h0000);
      model_reset();
      rst_n = 1'b1;
      wait_clk(2);
      cs = 1'b1;
      wait_clk(12);
      for (int k = 0; k < 3; k++) do_frame(16'hC200, 16);
      check("read2 after reset", resp_last[0], 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
